// File: rtl/instruction_cache_2way.sv
// instruction_cache_2way: two-way set-associative read-only instruction cache with LRU, multi-cycle flush and saturating hit/miss counters
module instruction_cache_2way #(
  parameter int LINE_WORDS = 4,
  parameter int SETS = 8,
  parameter int CNT_W = 32
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic [31:0]                             ADDRESS,
  input  logic                                    READ,
  input  logic                                    FLUSH,
  output logic [31:0]                             READDATA,
  output logic                                    BUSYWAIT,
  output logic [31-$clog2(LINE_WORDS*4):0]        MEM_ADDRESS,
  output logic                                    MEM_READ,
  input  logic [LINE_WORDS*32-1:0]                MEM_READDATA,
  input  logic                                    MEM_BUSYWAIT,
  output logic [CNT_W-1:0]                        HIT_COUNT,
  output logic [CNT_W-1:0]                        MISS_COUNT
);
  localparam int OB = $clog2(LINE_WORDS * 4);
  localparam int IB = $clog2(SETS);
  localparam int TB = 32 - IB - OB;
  localparam int LW = LINE_WORDS * 32;
  typedef enum logic [1:0] {IDLE, READ_MEM, FLUSHING} state_t;
  state_t state, next;
  logic [1:0] valid [SETS];
  logic [TB-1:0] tags [SETS][2];
  logic [LW-1:0] data [SETS][2];
  logic [SETS-1:0] lru;
  logic flush_pending;
  logic [IB-1:0] flush_cnt;
  logic [IB-1:0] idx, li;
  logic [TB-1:0] tag, lt;
  logic [31:0] off;
  logic hit0, hit1, hit, victim, hit_acc, miss_acc;
  logic [LW-1:0] hit_line;
  assign idx = ADDRESS[OB+IB-1:OB];
  assign tag = ADDRESS[31:32-TB];
  assign li = MEM_ADDRESS[IB-1:0];
  assign lt = MEM_ADDRESS[31-OB:IB];
  // byte offset of the requested word inside the line; zero for one-word lines
  assign off = ADDRESS & 32'(LINE_WORDS * 4 - 4);
  assign hit0 = valid[idx][0] && tags[idx][0] == tag;
  assign hit1 = valid[idx][1] && tags[idx][1] == tag;
  assign hit = hit0 | hit1;
  assign hit_line = hit1 ? data[idx][1] : data[idx][0];
  assign victim = !valid[li][0] ? 1'b0 : !valid[li][1] ? 1'b1 : lru[li];
  assign hit_acc = state == IDLE && READ && !FLUSH && hit;
  assign miss_acc = state == IDLE && READ && !FLUSH && !hit;
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : next;
  always_comb begin
    next = state;
    MEM_READ = state == READ_MEM;
    READDATA = (state == IDLE && hit) ? 32'(hit_line >> {off, 3'b000}) : 32'h0;
    BUSYWAIT = state != IDLE || FLUSH || (READ && !hit);
    next = state == IDLE ? (FLUSH ? FLUSHING : (READ && !hit) ? READ_MEM : IDLE)
         : state == READ_MEM ? (MEM_BUSYWAIT ? READ_MEM : (flush_pending || FLUSH) ? FLUSHING : IDLE)
         : (flush_cnt == IB'(SETS - 1)) ? IDLE : FLUSHING;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SETS; i++) valid[i] <= 2'b00;
      lru <= '0;
      flush_pending <= 1'b0;
      flush_cnt <= '0;
      MEM_ADDRESS <= '0;
      HIT_COUNT <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (hit_acc && HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 1'b1;
      if (miss_acc && MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 1'b1;
      if (hit_acc) lru[idx] <= hit0;
      if (miss_acc) MEM_ADDRESS <= ADDRESS[31:OB];
      if (state == IDLE) flush_cnt <= '0;
      if (state == READ_MEM && FLUSH) flush_pending <= 1'b1;
      if (state == READ_MEM && !MEM_BUSYWAIT) begin
        valid[li][victim] <= 1'b1;
        tags[li][victim] <= lt;
        data[li][victim] <= MEM_READDATA;
        lru[li] <= ~victim;
      end
      if (state == FLUSHING) begin
        valid[flush_cnt] <= 2'b00;
        lru[flush_cnt] <= 1'b0;
        flush_cnt <= flush_cnt + 1'b1;
        flush_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instruction_cache_2way.sv
// tb_instruction_cache_2way: directed and random fetches checked against a recency-list cache model
module tb_instruction_cache_2way;
  logic CLK = 0, RESET = 1, READ = 0, FLUSH = 0, MEM_BUSYWAIT = 1;
  logic [31:0] ADDRESS = 0, READDATA;
  logic BUSYWAIT, MEM_READ;
  logic [27:0] MEM_ADDRESS;
  logic [127:0] MEM_READDATA = 0;
  logic [3:0] HIT_COUNT, MISS_COUNT;
  int tests = 0, failed = 0, lat_cfg = 0, mcnt = 0;
  int m_hits = 0, m_misses = 0;
  logic [27:0] m_sets [8][$];

  instruction_cache_2way #(.LINE_WORDS(4), .SETS(8), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .READ(READ), .FLUSH(FLUSH),
    .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READ(MEM_READ), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT));

  always #5 CLK = ~CLK;

  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [31:0] b = 32'(la);
    if (la == 0) return 128'h44443333_22221111_00001111_00000013;
    return {b + 32'h3000_0000, b + 32'h2000_0000, b + 32'h1000_0000, b + 32'h5000_0000};
  endfunction

  // memory answers after lat_cfg busy cycles; garbage while busy
  always @(negedge CLK) begin
    if (MEM_READ) begin
      MEM_BUSYWAIT = mcnt < lat_cfg;
      MEM_READDATA = MEM_BUSYWAIT ? {4{32'hDEADBEEF}} : line_of(MEM_ADDRESS);
      mcnt++;
    end else begin
      mcnt = 0;
      MEM_BUSYWAIT = 1;
      MEM_READDATA = '0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_has(input logic [27:0] la);
    foreach (m_sets[la[2:0]][i]) if (m_sets[la[2:0]][i] == la) return 1;
    return 0;
  endfunction

  task automatic m_touch(input logic [27:0] la);
    int s = int'(la[2:0]);
    foreach (m_sets[s][i]) if (m_sets[s][i] == la) begin m_sets[s].delete(i); break; end
    if (m_sets[s].size() == 2) void'(m_sets[s].pop_front());
    m_sets[s].push_back(la);
  endtask

  task automatic m_clear();
    for (int s = 0; s < 8; s++) m_sets[s].delete();
  endtask

  function automatic int sat(input int v);
    return v >= 15 ? 15 : v + 1;
  endfunction

  task automatic fetch(input logic [31:0] a, input int lat);
    logic [27:0] la = a[31:4];
    logic [127:0] ln = line_of(la);
    bit h = m_has(la), seen = 0;
    int busy = 0;
    @(negedge CLK);
    lat_cfg = lat; ADDRESS = a; READ = 1; FLUSH = 0;
    #1;
    while (BUSYWAIT && busy < 60) begin
      if (MEM_READ && !seen) begin seen = 1; check("mem_address", 128'(MEM_ADDRESS), 128'(la)); end
      busy++;
      @(negedge CLK); #1;
    end
    check("busy_cycles", 128'(busy), 128'(h ? 0 : 2 + lat));
    check("readdata", 128'(READDATA), 128'(32'(ln >> (32 * int'(a[3:2])))));
    if (!h) m_misses = sat(m_misses);
    m_hits = sat(m_hits);
    m_touch(la);
  endtask

  task automatic check_counts();
    @(negedge CLK);
    READ = 0; FLUSH = 0;
    #1;
    check("hit_count", 128'(HIT_COUNT), 128'(m_hits));
    check("miss_count", 128'(MISS_COUNT), 128'(m_misses));
    check("mem_read_idle", 128'(MEM_READ), 128'(0));
  endtask

  task automatic flush_idle();
    int busy = 0;
    @(negedge CLK);
    READ = 0; FLUSH = 1;
    #1;
    while (BUSYWAIT && busy < 60) begin
      busy++;
      @(negedge CLK); FLUSH = 0; #1;
    end
    FLUSH = 0;
    check("flush_busy", 128'(busy), 128'(9));
    m_clear();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1; READ = 0; FLUSH = 0;
    @(negedge CLK);
    RESET = 0;
    m_clear(); m_hits = 0; m_misses = 0;
  endtask

  initial begin
    int busy;
    do_reset();
    ADDRESS = 0; READ = 1;
    #1;
    check("rst_busywait", 128'(BUSYWAIT), 128'(1));
    check("rst_readdata", 128'(READDATA), 128'(0));
    check("rst_mem_read", 128'(MEM_READ), 128'(0));
    check("rst_mem_address", 128'(MEM_ADDRESS), 128'(0));
    check("rst_hits", 128'(HIT_COUNT), 128'(0));
    check("rst_misses", 128'(MISS_COUNT), 128'(0));
    READ = 0;
    fetch(32'h0, 2);
    fetch(32'h8, 0);
    check_counts();
    check("first_miss_count", 128'(MISS_COUNT), 128'(1));
    check("first_hit_count", 128'(HIT_COUNT), 128'(2));

    do_reset();
    fetch(32'h000, 1);
    fetch(32'h080, 0);
    fetch(32'h000, 0);
    fetch(32'h100, 2);
    fetch(32'h000, 0);
    fetch(32'h080, 1);
    check_counts();
    check("lru_miss_count", 128'(MISS_COUNT), 128'(4));

    flush_idle();
    fetch(32'h004, 0);

    fetch(32'h200, 0);
    @(negedge CLK);
    ADDRESS = 32'h300; READ = 1; lat_cfg = 3;
    #1;
    busy = BUSYWAIT ? 1 : 0;
    @(negedge CLK);
    FLUSH = 1; READ = 0;
    #1;
    if (BUSYWAIT) busy++;
    @(negedge CLK);
    FLUSH = 0;
    #1;
    while (BUSYWAIT && busy < 60) begin
      busy++;
      @(negedge CLK); #1;
    end
    check("deferred_flush_busy", 128'(busy), 128'(13));
    m_misses = sat(m_misses);
    m_clear();
    check_counts();
    fetch(32'h300, 0);
    fetch(32'h200, 1);

    @(negedge CLK);
    ADDRESS = 32'h40; READ = 1; lat_cfg = 10;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("midmiss_mem_read", 128'(MEM_READ), 128'(1));
    RESET = 1; READ = 0;
    @(negedge CLK);
    #1;
    check("abort_mem_read", 128'(MEM_READ), 128'(0));
    check("abort_hits", 128'(HIT_COUNT), 128'(0));
    check("abort_misses", 128'(MISS_COUNT), 128'(0));
    check("abort_busywait", 128'(BUSYWAIT), 128'(0));
    RESET = 0;
    m_clear(); m_hits = 0; m_misses = 0;
    fetch(32'h40, 1);

    for (int i = 0; i < 20; i++) fetch(32'h44, 0);
    check_counts();
    check("saturated_hits", 128'(HIT_COUNT), 128'(15));

    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) flush_idle();
      else fetch({23'h0, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'b00},
                 int'($urandom_range(0, 3)));
    end
    check_counts();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/instruction_cache_2way.md
# instruction_cache_2way

Two-way set-associative, parametrised instruction cache for the RV32IM pipeline, sitting between the IF-stage PC and the line-wide instruction memory. It replaces the direct-mapped cache with LRU replacement and a configurable geometry. It adds a FLUSH input for fence.i that clears the array over multiple cycles, plus saturating hit/miss counters. The cache is read-only; the stall to the pipeline is signalled by BUSYWAIT.

## Interface
- LINE_WORDS, default 4: 32-bit words per line; power of two, ≥1. OFFSET_BITS = log2(LINE_WORDS*4).
- SETS, default 8: number of sets; power of two, ≥2. INDEX_BITS = log2(SETS); TAG_BITS = 32 − INDEX_BITS − OFFSET_BITS.
- CNT_W, default 32: width of the hit and miss counters.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDRESS  in  32  fetch byte address (PC); bits [1:0] ignored.
- READ  in  1  fetch request valid.
- FLUSH  in  1  invalidate-all request (fence.i); single-cycle pulse.
- READDATA  out  32  fetched instruction.
- BUSYWAIT  out  1  stall to the pipeline.
- MEM_ADDRESS  out  32−OFFSET_BITS  line address to memory.
- MEM_READ  out  1  line read request.
- MEM_READDATA  in  LINE_WORDS*32  line from memory; word 0 in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; line is valid in the cycle it is low while MEM_READ=1.
- HIT_COUNT  out  CNT_W  accepted hits, saturating.
- MISS_COUNT  out  CNT_W  misses, saturating.

## Operation
- Per set: 2 ways of {VALID, TAG, DATA line} and one LRU bit. LRU=w means way w is the next victim.
- Lookup is combinational on ADDRESS. A hit in way w requires VALID[w] and TAG[w] == ADDRESS[31:32−TAG_BITS]. Both ways cannot hit.
- READDATA is the hit line's word ADDRESS[OFFSET_BITS−1:2] when in IDLE with a hit; otherwise it is 32'h0.
- BUSYWAIT = (state != IDLE) | (IDLE & READ & !hit) | (IDLE & FLUSH).
- The state machine has three states: IDLE, READ_MEM and FLUSHING.
- IDLE, when FLUSH=1: go to FLUSHING with flush counter = 0. FLUSH has priority over a miss.
- IDLE, when READ=1, miss and FLUSH=0: latch the line address ADDRESS[31:OFFSET_BITS] into MEM_ADDRESS, increment MISS_COUNT, and go to READ_MEM.
- IDLE, when READ=1, hit and FLUSH=0: increment HIT_COUNT and set LRU[set] = the other way.
- READ_MEM: MEM_READ=1, MEM_ADDRESS holds the latched value.
  - The victim is way 0 if it is invalid, else way 1 if it is invalid, else way LRU[set]. It is chosen on the latched index.
  - On an edge with MEM_BUSYWAIT=0: write MEM_READDATA, the tag and VALID=1 into the victim way. Set LRU[set] = the other way. Go to IDLE.
- While in READ_MEM, ADDRESS changes are ignored. After return to IDLE, lookup uses the current ADDRESS.
- FLUSH asserted while in READ_MEM sets flush_pending. The fill completes, then the FSM enters FLUSHING instead of IDLE.
- FLUSHING: each cycle clears VALID of both ways and LRU of set flush counter, then increments the counter. After clearing set SETS−1, go to IDLE. FLUSH is ignored while in FLUSHING.
- Counters stop at 2^CNT_W−1. Only RESET clears them.

## Timing
- RESET, sampled high at an edge, sets:
  - state IDLE;
  - all VALID=0 and all LRU=0;
  - flush_pending=0;
  - both counters 0;
  - MEM_READ=0 and MEM_ADDRESS=0.
- After reset, READDATA=0, and BUSYWAIT = READ (every lookup misses).
- RESET during READ_MEM or FLUSHING aborts the operation. A partial fill is never written.
- Hit latency: 0 cycles. Data and BUSYWAIT=0 appear in the same cycle the ADDRESS is presented.
- Miss latency with memory ready in the first READ_MEM cycle:
  - cycle 0 is the IDLE miss, cycle 1 is READ_MEM with the fill at its closing edge;
  - cycle 2 is IDLE with a hit.
  - BUSYWAIT is high for 2 cycles, plus 1 cycle for each extra cycle MEM_BUSYWAIT stays high.
- A flush from IDLE holds BUSYWAIT for 1 + SETS cycles.
- MEM_READ is asserted only in READ_MEM. It drops in the cycle after the fill edge.

## Test plan
- Fetch after reset: RESET, then READ=1 with ADDRESS=0x0 and memory returning 0x44443333_22221111_00001111_00000013 after 2 busy cycles.
  - Required: MEM_READ with MEM_ADDRESS=0x0000000, BUSYWAIT high for 4 cycles.
  - Then READDATA=0x00000013 with BUSYWAIT=0; ADDRESS=0x8 then gives 0x22221111 with zero wait.
  - MISS_COUNT=1 and HIT_COUNT=2.
- LRU eviction: fetch 0x000 and 0x080 (both set 0), hit 0x000, then fetch 0x100.
  - Required: 0x100 evicts the 0x080 line; 0x000 then hits and 0x080 misses.
  - MISS_COUNT=4.
- Flush from IDLE: with 0x000 cached, pulse FLUSH for 1 cycle.
  - Required: BUSYWAIT high for 9 cycles; the next fetch of 0x000 misses.
- Deferred flush: pulse FLUSH during READ_MEM.
  - Required: the fill completes, then 8 FLUSHING cycles; the filled line is invalid afterwards.
- Reset mid-miss: assert RESET while in READ_MEM.
  - Required: MEM_READ=0 and both counters 0 after the edge; a refetch of the same address misses.
- Counter saturation: with CNT_W=4, perform 20 hits.
  - Required: HIT_COUNT holds 15.
